// File: rtl/ram_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ram_read_sequencer
// Description : Replays each ram_logic buffer to every enabled consumer in
//               ascending index order over one shared read port.
//               Optional stall watchdog enabled by defining RRS_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_read_sequencer #(
    parameter int NUM_CONSUMERS  = 3,
    parameter int BUFFER_DEPTH   = 16,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     ram_buffer_ready_i,
    input  logic [23:0]              ram_read_data_i,
    input  logic                     ram_read_valid_i,
    output logic                     ram_read_ready_o,
    output logic                     ram_rewind_o,
    input  logic [NUM_CONSUMERS-1:0] cons_enable_i,
    output logic [NUM_CONSUMERS-1:0] cons_buffer_ready_o,
    output logic [23:0]              cons_read_data_o,
    output logic [NUM_CONSUMERS-1:0] cons_read_valid_o,
    input  logic [NUM_CONSUMERS-1:0] cons_read_ready_i,
    output logic [NUM_CONSUMERS-1:0] grant_o,
    output logic                     busy_o,
    output logic [7:0]               overrun_count_o,
    output logic                     timeout_o
);

    localparam int                    C_BEAT_W    = $clog2(BUFFER_DEPTH) + 1;
    localparam logic [C_BEAT_W-1:0]   C_BEAT_LAST = C_BEAT_W'(BUFFER_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REWIND   = 3'd1,
        S_ANNOUNCE = 3'd2,
        S_STREAM   = 3'd3,
        S_NEXT     = 3'd4
    } state_t;

    state_t                     r_state_q,   w_state_d;
    logic [NUM_CONSUMERS-1:0]   r_grant_q,   w_grant_d;
    logic [NUM_CONSUMERS-1:0]   r_pending_q, w_pending_d;
    logic [C_BEAT_W-1:0]        r_beat_q,    w_beat_d;
    logic [7:0]                 r_ovf_q,     w_ovf_d;
    logic [NUM_CONSUMERS-1:0]   w_remaining;
    logic                       w_owner_ready;
    logic                       w_beat;
    logic                       w_timeout;

    function automatic logic [NUM_CONSUMERS-1:0] f_lowest(input logic [NUM_CONSUMERS-1:0] v);
        f_lowest = '0;
        for (int i = NUM_CONSUMERS - 1; i >= 0; i--) begin
            if (v[i]) begin
                f_lowest    = '0;
                f_lowest[i] = 1'b1;
            end
        end
    endfunction

    assign w_owner_ready = |(cons_read_ready_i & r_grant_q);
    assign w_beat        = (r_state_q == S_STREAM) && ram_read_valid_i && w_owner_ready;
    assign w_remaining   = r_pending_q & ~r_grant_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q   <= S_IDLE;
            r_grant_q   <= '0;
            r_pending_q <= '0;
            r_beat_q    <= '0;
            r_ovf_q     <= 8'd0;
        end else begin
            r_state_q   <= w_state_d;
            r_grant_q   <= w_grant_d;
            r_pending_q <= w_pending_d;
            r_beat_q    <= w_beat_d;
            r_ovf_q     <= w_ovf_d;
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_grant_d   = r_grant_q;
        w_pending_d = r_pending_q;
        w_beat_d    = r_beat_q;
        w_ovf_d     = r_ovf_q;

        case (r_state_q)
            S_IDLE: begin
                // The first consumer reads from buffer start, so no rewind here
                if (ram_buffer_ready_i && (cons_enable_i != '0)) begin
                    w_pending_d = cons_enable_i;
                    w_grant_d   = f_lowest(cons_enable_i);
                    w_state_d   = S_ANNOUNCE;
                end
            end
            S_REWIND: begin
                w_state_d = S_ANNOUNCE;
            end
            S_ANNOUNCE: begin
                w_beat_d  = '0;
                w_state_d = S_STREAM;
            end
            S_STREAM: begin
                if (w_beat) begin
                    w_beat_d = r_beat_q + C_BEAT_W'(1);
                    if (r_beat_q == C_BEAT_LAST) begin
                        w_state_d = S_NEXT;
                    end
                end else if (w_timeout) begin
                    w_state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                w_pending_d = w_remaining;
                if (w_remaining != '0) begin
                    w_grant_d = f_lowest(w_remaining);
                    w_state_d = S_REWIND;
                end else begin
                    w_grant_d = '0;
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_grant_d   = '0;
                w_pending_d = '0;
                w_state_d   = S_IDLE;
            end
        endcase

        if (ram_buffer_ready_i && (r_state_q != S_IDLE) && (r_ovf_q != 8'hFF)) begin
            w_ovf_d = r_ovf_q + 8'd1;
        end
    end

`ifdef RRS_TIMEOUT_EN
    localparam int                  C_STALL_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [C_STALL_W-1:0] C_STALL_LAST = C_STALL_W'(TIMEOUT_CYCLES - 1);

    logic [C_STALL_W-1:0] r_stall_q, w_stall_d;

    // Held at zero outside STREAM so every consumer starts with a fresh budget
    always_comb begin
        w_stall_d = '0;
        if ((r_state_q == S_STREAM) && !w_beat) begin
            w_stall_d = r_stall_q + C_STALL_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_q <= '0;
        end else begin
            r_stall_q <= w_stall_d;
        end
    end

    assign w_timeout = (r_state_q == S_STREAM) && !w_beat && (r_stall_q == C_STALL_LAST);
`else
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_disabled
    end

    assign w_timeout = 1'b0;
`endif

    assign ram_read_ready_o    = (r_state_q == S_STREAM) && w_owner_ready;
    assign ram_rewind_o        = (r_state_q == S_REWIND);
    assign cons_buffer_ready_o = (r_state_q == S_ANNOUNCE) ? r_grant_q : '0;
    assign cons_read_data_o    = ram_read_data_i;
    assign cons_read_valid_o   = ((r_state_q == S_STREAM) && ram_read_valid_i) ? r_grant_q : '0;
    assign grant_o             = r_grant_q;
    assign busy_o              = (r_state_q != S_IDLE);
    assign overrun_count_o     = r_ovf_q;
    assign timeout_o           = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ram_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_read_sequencer
// Description : Directed self-checking bench for ram_read_sequencer with a
//               small RAM read-pointer model supplying sample data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_read_sequencer;

    localparam int          N     = 3;
    localparam logic [23:0] DBASE = 24'hA50000;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          ram_buffer_ready_i;
    logic [23:0]   ram_read_data_i;
    logic          ram_read_valid_i;
    logic          ram_read_ready_o;
    logic          ram_rewind_o;
    logic [N-1:0]  cons_enable_i;
    logic [N-1:0]  cons_buffer_ready_o;
    logic [23:0]   cons_read_data_o;
    logic [N-1:0]  cons_read_valid_o;
    logic [N-1:0]  cons_read_ready_i;
    logic [N-1:0]  grant_o;
    logic          busy_o;
    logic [7:0]    overrun_count_o;
    logic          timeout_o;

    int n_cmp = 0;
    int n_err = 0;
    int n_beat [N];
    int n_ann  [N];
    int exp_idx[N];
    int n_rewind, n_busy, n_timeout, n_stray, n_badgrant;
    int rd_ptr;
    bit toggle0;

    logic [N-1:0] last_grant, last_cbr, last_valid;
    logic         last_busy, last_rdy, last_rewind;
    logic [7:0]   last_ovf;

    ram_read_sequencer #(
        .NUM_CONSUMERS (N),
        .BUFFER_DEPTH  (16),
        .TIMEOUT_CYCLES(65536)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .ram_buffer_ready_i (ram_buffer_ready_i),
        .ram_read_data_i    (ram_read_data_i),
        .ram_read_valid_i   (ram_read_valid_i),
        .ram_read_ready_o   (ram_read_ready_o),
        .ram_rewind_o       (ram_rewind_o),
        .cons_enable_i      (cons_enable_i),
        .cons_buffer_ready_o(cons_buffer_ready_o),
        .cons_read_data_o   (cons_read_data_o),
        .cons_read_valid_o  (cons_read_valid_o),
        .cons_read_ready_i  (cons_read_ready_i),
        .grant_o            (grant_o),
        .busy_o             (busy_o),
        .overrun_count_o    (overrun_count_o),
        .timeout_o          (timeout_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        for (int k = 0; k < N; k++) begin
            n_beat[k]  = 0;
            n_ann[k]   = 0;
            exp_idx[k] = 0;
        end
        n_rewind   = 0;
        n_busy     = 0;
        n_timeout  = 0;
        n_stray    = 0;
        n_badgrant = 0;
    endtask

    // One clock: drive inputs, observe settled outputs, advance the RAM model
    task automatic cycle();
        if (toggle0) cons_read_ready_i[0] = ~cons_read_ready_i[0];
        ram_read_data_i = DBASE + 24'(rd_ptr);
        #1;
        last_grant  = grant_o;
        last_cbr    = cons_buffer_ready_o;
        last_valid  = cons_read_valid_o;
        last_busy   = busy_o;
        last_rdy    = ram_read_ready_o;
        last_rewind = ram_rewind_o;
        last_ovf    = overrun_count_o;
        if (ram_rewind_o) n_rewind++;
        if (busy_o)       n_busy++;
        if (timeout_o)    n_timeout++;
        for (int k = 0; k < N; k++) begin
            if (cons_buffer_ready_o[k]) begin
                n_ann[k]++;
                exp_idx[k] = 0;
            end
            if (cons_read_valid_o[k] && cons_read_ready_i[k]) begin
                chk($sformatf("data_c%0d_b%0d", k, exp_idx[k]),
                    32'(cons_read_data_o), 32'(DBASE + 24'(exp_idx[k])));
                exp_idx[k]++;
                n_beat[k]++;
            end
        end
        if ((cons_read_valid_o & ~grant_o) != '0) n_stray++;
        if (!$onehot0(grant_o)) n_badgrant++;
        if (ram_read_ready_o && ram_read_valid_i) rd_ptr++;
        if (ram_rewind_o) rd_ptr = 0;
        @(negedge clk);
    endtask

    task automatic start_buf();
        rd_ptr = 0;
        ram_buffer_ready_i = 1'b1;
        cycle();
        ram_buffer_ready_i = 1'b0;
    endtask

    task automatic run_until_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            cycle();
            if (!last_busy) break;
        end
        chk("idle_reached", 32'(last_busy), 32'd0);
    endtask

    task automatic chk_beats(input string tag, input int e0, input int e1, input int e2);
        chk({tag, "_beats_c0"}, 32'(n_beat[0]), 32'(e0));
        chk({tag, "_beats_c1"}, 32'(n_beat[1]), 32'(e1));
        chk({tag, "_beats_c2"}, 32'(n_beat[2]), 32'(e2));
        chk({tag, "_stray_valid"}, 32'(n_stray), 32'd0);
        chk({tag, "_grant_onehot"}, 32'(n_badgrant), 32'd0);
        chk({tag, "_timeout"}, 32'(n_timeout), 32'd0);
    endtask

    initial begin
        rst_i              = 1'b1;
        ram_buffer_ready_i = 1'b0;
        ram_read_data_i    = '0;
        ram_read_valid_i   = 1'b0;
        cons_enable_i      = '0;
        cons_read_ready_i  = '0;
        toggle0            = 1'b0;
        rd_ptr             = 0;
        clear_stats();
        @(negedge clk);

        // Reset state
        repeat (3) cycle();
        rst_i = 1'b0;
        cycle();
        chk("rst_grant",   32'(last_grant),  32'd0);
        chk("rst_busy",    32'(last_busy),   32'd0);
        chk("rst_ovf",     32'(last_ovf),    32'd0);
        chk("rst_rewind",  32'(last_rewind), 32'd0);
        chk("rst_cbr",     32'(last_cbr),    32'd0);
        chk("rst_valid",   32'(last_valid),  32'd0);
        chk("rst_ram_rdy", 32'(last_rdy),    32'd0);

        // Buffer-ready with no consumer enabled is neither served nor an overrun
        ram_read_valid_i  = 1'b1;
        cons_read_ready_i = 3'b111;
        start_buf();
        cycle();
        chk("noen_busy", 32'(last_busy), 32'd0);
        chk("noen_ovf",  32'(last_ovf),  32'd0);

        // All three consumers, full throughput
        clear_stats();
        cons_enable_i = 3'b111;
        start_buf();
        cycle();
        chk("t1_announce_c0", 32'(last_cbr),   32'b001);
        chk("t1_grant_c0",    32'(last_grant), 32'b001);
        chk("t1_valid_ann",   32'(last_valid), 32'd0);
        chk("t1_ramrdy_ann",  32'(last_rdy),   32'd0);
        cycle();
        chk("t1_first_beat",  32'(last_valid), 32'b001);
        run_until_idle(100);
        chk_beats("t1", 16, 16, 16);
        chk("t1_rewinds",  32'(n_rewind), 32'd2);
        chk("t1_busy_len", 32'(n_busy),   32'd56);
        chk("t1_ann_c1",   32'(n_ann[1]), 32'd1);
        chk("t1_ann_c2",   32'(n_ann[2]), 32'd1);
        chk("t1_grant_idle", 32'(last_grant), 32'd0);

        // Consumers 0 and 2 only
        clear_stats();
        cons_enable_i = 3'b101;
        start_buf();
        run_until_idle(100);
        chk_beats("t2", 16, 0, 16);
        chk("t2_rewinds",  32'(n_rewind), 32'd1);
        chk("t2_ann_c1",   32'(n_ann[1]), 32'd0);
        chk("t2_ann_c2",   32'(n_ann[2]), 32'd1);
        chk("t2_busy_len", 32'(n_busy),   32'd37);

        // Consumer 0 alone with ready toggling every cycle
        clear_stats();
        cons_enable_i     = 3'b001;
        cons_read_ready_i = 3'b000;
        toggle0           = 1'b1;
        start_buf();
        run_until_idle(100);
        toggle0           = 1'b0;
        cons_read_ready_i = 3'b111;
        chk_beats("t3", 16, 0, 0);
        chk("t3_rewinds", 32'(n_rewind), 32'd0);

        // Overrun during STREAM and during the final NEXT cycle
        clear_stats();
        cons_enable_i = 3'b111;
        start_buf();
        repeat (5) cycle();
        ram_buffer_ready_i = 1'b1;
        cycle();
        ram_buffer_ready_i = 1'b0;
        for (int i = 0; i < 100 && n_beat[2] < 16; i++) cycle();
        chk("t4_c2_done", 32'(n_beat[2]), 32'd16);
        ram_buffer_ready_i = 1'b1;
        cycle();
        ram_buffer_ready_i = 1'b0;
        chk("t4_next_busy",  32'(last_busy),  32'd1);
        chk("t4_next_grant", 32'(last_grant), 32'b100);
        cycle();
        chk("t4_dropped_idle", 32'(last_busy), 32'd0);
        chk("t4_ovf2",         32'(last_ovf),  32'd2);
        chk_beats("t4", 16, 16, 16);
        chk("t4_rewinds", 32'(n_rewind), 32'd2);

        // Saturation with the stream stalled on valid
        clear_stats();
        start_buf();
        cycle();
        ram_read_valid_i   = 1'b0;
        ram_buffer_ready_i = 1'b1;
        repeat (252) cycle();
        ram_buffer_ready_i = 1'b0;
        cycle();
        chk("t4_ovf254", 32'(last_ovf), 32'd254);
        ram_buffer_ready_i = 1'b1;
        repeat (48) cycle();
        ram_buffer_ready_i = 1'b0;
        cycle();
        chk("t4_ovf_sat", 32'(last_ovf), 32'd255);
        ram_read_valid_i = 1'b1;
        run_until_idle(100);
        chk_beats("t4s", 16, 16, 16);
        chk("t4_ovf_final", 32'(overrun_count_o), 32'd255);

        // Reset in the middle of consumer 1
        clear_stats();
        start_buf();
        for (int i = 0; i < 100 && n_beat[1] < 7; i++) cycle();
        chk("t5_c1_beat7", 32'(n_beat[1]), 32'd7);
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        cycle();
        chk("t5_grant", 32'(last_grant), 32'd0);
        chk("t5_valid", 32'(last_valid), 32'd0);
        chk("t5_busy",  32'(last_busy),  32'd0);
        chk("t5_ovf",   32'(last_ovf),   32'd0);
        clear_stats();
        start_buf();
        cycle();
        chk("t5_restart_c0",  32'(last_cbr),  32'b001);
        chk("t5_no_rewind",   32'(n_rewind),  32'd0);
        run_until_idle(100);
        chk_beats("t5", 16, 16, 16);
        chk("t5_rewinds", 32'(n_rewind), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
